axis_update_sequencer: RTL and testbench
========================================

# axis_update_sequencer

Sequencer that time-shares one external 16-bit add/subtract datapath across the X, Y and Z axis position registers of the spacecraft spatial-position unit. On each `start` it steps all three axes by their per-axis step values, in turn, over three consecutive cycles. It owns the position registers and reports signed overflow per axis. It sits between the command/attitude logic that issues steps and the shared ripple-carry adder.

## Interface
- `WIDTH`, 16: position, step and adder width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to step all three axes; sampled only in IDLE.
- `step_x`, `step_y`, `step_z`  in  WIDTH each  two's-complement step operands; sampled in their axis phase.
- `dir_x`, `dir_y`, `dir_z`  in  1 each  0 = position + step, 1 = position − step.
- `load`  in  1  direct position load; accepted only in IDLE.
- `load_sel`  in  3  one-hot axis select for `load`: bit0 = X, bit1 = Y, bit2 = Z.
- `load_val`  in  WIDTH  value written by `load`.
- `add_mode`  out  1  subtract select to the shared adder.
- `add_a`, `add_b`  out  WIDTH each  adder operands.
- `add_cin`  out  1  adder carry-in.
- `add_sum`  in  WIDTH  adder result, combinational from `add_a`/`add_b`/`add_mode`/`add_cin`.
- `pos_x`, `pos_y`, `pos_z`  out  WIDTH each  registered signed positions.
- `ovf`  out  3  sticky per-axis overflow flags; bit0 = X, bit1 = Y, bit2 = Z.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at the end of a sequence.

## Operation
- FSM states: IDLE, AX_X, AX_Y, AX_Z, DONE.
- IDLE → AX_X on `start`. AX_X → AX_Y → AX_Z → DONE → IDLE unconditionally, one cycle each.
- Axis phase drives `add_a` = that axis's position, `add_b` = that axis's step, `add_mode` = that axis's dir, `add_cin` = that axis's dir.
- In IDLE and DONE, all four adder outputs are 0.
- The rising edge ending an axis phase writes `add_sum` into that axis's position register.
- Signed overflow is evaluated with `s` = `add_sum`:
  - add: sign(a) == sign(b) and sign(s) != sign(a);
  - subtract: sign(a) != sign(b) and sign(s) != sign(a).
- On overflow, set that axis's `ovf` bit. The bit is cleared only by `rst` or by a `load` to that axis.
- `load` in IDLE writes `load_val` to every axis selected in `load_sel` (multiple bits allowed) and clears the matching `ovf` bits.
- `load` and `start` in the same IDLE cycle: `load` executes and `start` is dropped.
- `start` or `load` while `busy` is ignored; there is no queueing.
- `load_sel` = 0 with `load` asserted: no effect.
- Reset values: `pos_*` = 0, `ovf` = 0, `busy` = 0, `done` = 0, adder outputs = 0, state = IDLE.
- `rst` mid-sequence aborts immediately. Positions already written in that sequence are also reset to 0.

## Timing
- `start` high in IDLE at cycle N:
  - AX_X in N+1; `pos_x` new value visible N+2.
  - AX_Y in N+2; `pos_y` visible N+3.
  - AX_Z in N+3; `pos_z` visible N+4.
  - DONE in N+4, with `done` = 1 in N+4 only; IDLE in N+5.
- Start-to-done latency: 4 cycles. Minimum start-to-start spacing: 5 cycles.
- `busy` = 1 from N+1 through N+4.
- `ovf` bit updates on the same edge as its position.
- `load` in IDLE at cycle M: position and `ovf` change visible M+1.
- Step and dir inputs need only be valid during their own axis phase.

## Configuration
- `AXIS_SATURATE_EN` defined:
  - on overflow the position register takes the saturated value: 0x7FFF…F when the true result is positive, 0x800…0 when negative;
  - `ovf` is still set.
- Not defined: the position takes the wrapped `add_sum`; `ovf` is still set.

## Test plan
- Reset, then idle 3 cycles: all outputs 0, `busy` = 0, adder outputs 0.
- `pos_x` = 5, `step_x` = 3, `dir_x` = 0; `pos_y` = 0, `step_y` = 1, `dir_y` = 1; `step_z` = 0. Pulse `start`:
  - `pos_x` = 0x0008 at N+2 and `pos_y` = 0xFFFF at N+3; `pos_z` unchanged;
  - `done` only at N+4; `ovf` = 0.
- Load X = 0x7FFF, then `start` with `step_x` = 1, `dir_x` = 0:
  - without macro, `pos_x` = 0x8000 and `ovf[0]` = 1;
  - with `AXIS_SATURATE_EN`, `pos_x` = 0x7FFF and `ovf[0]` = 1;
  - a subsequent `load` to X clears `ovf[0]`.
- `start` re-asserted at N+2, and `load` with `load_sel` = 0b111 at N+3: both ignored, sequence completes normally, next IDLE `start` accepted.
- `rst` asserted in AX_Y after X was updated: at the next edge all positions = 0, state IDLE, `done` never pulses.
- `load` and `start` together in IDLE with `load_sel` = 0b010, `load_val` = 0x1234: `pos_y` = 0x1234, `busy` stays 0.

Source files
------------

// File: rtl/axis_update_sequencer.sv
// Time-shares one external add/subtract datapath across the X, Y and Z position registers.
// Optional AXIS_SATURATE_EN: clamp positions on signed overflow instead of wrapping.
module axis_update_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] step_x,
  input  logic [WIDTH-1:0] step_y,
  input  logic [WIDTH-1:0] step_z,
  input  logic             dir_x,
  input  logic             dir_y,
  input  logic             dir_z,
  input  logic             load,
  input  logic [2:0]       load_sel,
  input  logic [WIDTH-1:0] load_val,
  output logic             add_mode,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] pos_x,
  output logic [WIDTH-1:0] pos_y,
  output logic [WIDTH-1:0] pos_z,
  output logic [2:0]       ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NUM_AXES = 3;
  localparam int unsigned MSB      = WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AX_X = 3'd1,
    AX_Y = 3'd2,
    AX_Z = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     pos_q [NUM_AXES];
  logic [NUM_AXES-1:0]  ovf_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 ovf_c;
  logic [WIDTH-1:0]     wr_val_c;

  // Adder operands follow the live axis phase so step/dir only need to be valid then.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_mode = 1'b0;
    add_cin  = 1'b0;
    case (state)
      AX_X: begin
        add_a    = pos_q[0];
        add_b    = step_x;
        add_mode = dir_x;
        add_cin  = dir_x;
      end
      AX_Y: begin
        add_a    = pos_q[1];
        add_b    = step_y;
        add_mode = dir_y;
        add_cin  = dir_y;
      end
      AX_Z: begin
        add_a    = pos_q[2];
        add_b    = step_z;
        add_mode = dir_z;
        add_cin  = dir_z;
      end
      default: begin
        add_a    = '0;
        add_b    = '0;
        add_mode = 1'b0;
        add_cin  = 1'b0;
      end
    endcase
  end

  // Signed overflow from operand and result signs; subtract flips the b-sign test.
  always_comb begin
    ovf_c = 1'b0;
    if (add_mode) begin
      ovf_c = (add_a[MSB] != add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);
    end else begin
      ovf_c = (add_a[MSB] == add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);
    end
  end

`ifdef AXIS_SATURATE_EN
  // On overflow the true result always carries the sign of operand a.
  always_comb begin
    wr_val_c = add_sum;
    if (ovf_c) begin
      wr_val_c = add_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    wr_val_c = add_sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ovf_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) begin
        pos_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // A load wins over a simultaneous start; the start is dropped.
          if (load) begin
            for (int i = 0; i < NUM_AXES; i++) begin
              if (load_sel[i]) begin
                pos_q[i] <= load_val;
                ovf_q[i] <= 1'b0;
              end
            end
          end else if (start) begin
            state  <= AX_X;
            busy_q <= 1'b1;
          end
        end
        AX_X: begin
          pos_q[0] <= wr_val_c;
          if (ovf_c) ovf_q[0] <= 1'b1;
          state <= AX_Y;
        end
        AX_Y: begin
          pos_q[1] <= wr_val_c;
          if (ovf_c) ovf_q[1] <= 1'b1;
          state <= AX_Z;
        end
        AX_Z: begin
          pos_q[2] <= wr_val_c;
          if (ovf_c) ovf_q[2] <= 1'b1;
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign pos_x = pos_q[0];
  assign pos_y = pos_q[1];
  assign pos_z = pos_q[2];
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_axis_update_sequencer.sv
// Directed bench for axis_update_sequencer with a behavioural model of the shared adder.
module tb_axis_update_sequencer;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] step_x, step_y, step_z;
  logic             dir_x, dir_y, dir_z;
  logic             load;
  logic [2:0]       load_sel;
  logic [WIDTH-1:0] load_val;
  logic             add_mode;
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] pos_x, pos_y, pos_z;
  logic [2:0]       ovf;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  axis_update_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step_x   (step_x),
    .step_y   (step_y),
    .step_z   (step_z),
    .dir_x    (dir_x),
    .dir_y    (dir_y),
    .dir_z    (dir_z),
    .load     (load),
    .load_sel (load_sel),
    .load_val (load_val),
    .add_mode (add_mode),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .pos_z    (pos_z),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // External ripple-carry adder: subtract is a + ~b + cin.
  assign add_sum = add_a + (add_b ^ {WIDTH{add_mode}}) + WIDTH'(add_cin);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load = 1'b0; load_sel = 3'b000; load_val = '0;
    step_x = '0; step_y = '0; step_z = '0; dir_x = 1'b0; dir_y = 1'b0; dir_z = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();

    // Reset / idle state
    check("rst_pos_x", 32'(pos_x), 32'h0);
    check("rst_pos_y", 32'(pos_y), 32'h0);
    check("rst_pos_z", 32'(pos_z), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_adder", 32'({add_mode, add_cin, add_a, add_b}), 32'h0);

    // Basic sequence: x 5+3, y 0-1, z +0
    load = 1'b1; load_sel = 3'b001; load_val = 16'd5;
    tick();
    load = 1'b0; load_sel = 3'b000;
    check("load_x5", 32'(pos_x), 32'h5);
    step_x = 16'd3; dir_x = 1'b0;
    step_y = 16'd1; dir_y = 1'b1;
    step_z = 16'd0; dir_z = 1'b0;
    start = 1'b1;                       // cycle N
    tick(); start = 1'b0;               // N+1: AX_X
    check("n1_busy", 32'(busy), 32'h1);
    check("n1_add_a", 32'(add_a), 32'h5);
    check("n1_add_b", 32'(add_b), 32'h3);
    check("n1_mode_cin", 32'({add_mode, add_cin}), 32'h0);
    tick();                             // N+2: AX_Y
    check("n2_pos_x", 32'(pos_x), 32'h8);
    check("n2_pos_y_old", 32'(pos_y), 32'h0);
    check("n2_mode_cin", 32'({add_mode, add_cin}), 32'h3);
    check("n2_done", 32'(done), 32'h0);
    tick();                             // N+3: AX_Z
    check("n3_pos_y", 32'(pos_y), 32'hFFFF);
    check("n3_done", 32'(done), 32'h0);
    tick();                             // N+4: DONE
    check("n4_done", 32'(done), 32'h1);
    check("n4_busy", 32'(busy), 32'h1);
    check("n4_pos_z", 32'(pos_z), 32'h0);
    check("n4_adder", 32'({add_mode, add_cin, add_a, add_b}), 32'h0);
    tick();                             // N+5: IDLE
    check("n5_done", 32'(done), 32'h0);
    check("n5_busy", 32'(busy), 32'h0);
    check("n5_ovf", 32'(ovf), 32'h0);

    // Overflow on X: 0x7FFF + 1; y FFFF-1, z +0
    load = 1'b1; load_sel = 3'b001; load_val = 16'h7FFF;
    tick();
    load = 1'b0; load_sel = 3'b000;
    step_x = 16'd1; dir_x = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
`ifdef AXIS_SATURATE_EN
    check("ovf_pos_x", 32'(pos_x), 32'h7FFF);
`else
    check("ovf_pos_x", 32'(pos_x), 32'h8000);
`endif
    check("ovf_bit_x", 32'(ovf), 32'h1);
    tick(); tick(); tick();
    check("ovf_pos_y", 32'(pos_y), 32'hFFFE);
    check("ovf_sticky", 32'(ovf), 32'h1);
    load = 1'b1; load_sel = 3'b001; load_val = 16'h0000;
    tick();
    load = 1'b0; load_sel = 3'b000;
    check("ovf_clear", 32'(ovf), 32'h0);
    check("ovf_clear_pos", 32'(pos_x), 32'h0);

    // Start and load while busy are ignored
    start = 1'b1;                       // N
    tick(); start = 1'b0;               // N+1
    tick(); start = 1'b1;               // N+2
    tick(); start = 1'b0;               // N+3
    load = 1'b1; load_sel = 3'b111; load_val = 16'h5555;
    tick();                             // N+4
    load = 1'b0; load_sel = 3'b000;
    check("busy_ign_done", 32'(done), 32'h1);
    check("busy_ign_pos_x", 32'(pos_x), 32'h1);
    check("busy_ign_pos_y", 32'(pos_y), 32'hFFFD);
    check("busy_ign_pos_z", 32'(pos_z), 32'h0);
    tick();                             // N+5
    check("busy_ign_idle", 32'(busy), 32'h0);
    tick();
    check("busy_ign_noq", 32'(busy), 32'h0);
    start = 1'b1;
    tick(); start = 1'b0;
    check("restart_busy", 32'(busy), 32'h1);
    check("restart_add_a", 32'(add_a), 32'h1);
    tick(); tick(); tick(); tick();
    check("restart_pos_x", 32'(pos_x), 32'h2);
    check("restart_idle", 32'(busy), 32'h0);

    // Reset in AX_Y after X was written
    start = 1'b1;
    tick(); start = 1'b0;               // AX_X
    tick();                             // AX_Y
    check("abort_pre_x", 32'(pos_x), 32'h3);
    rst = 1'b1;
    tick();
    check("abort_pos", 32'({pos_x, pos_y}), 32'h0);
    check("abort_pos_z", 32'(pos_z), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_adder", 32'({add_mode, add_cin, add_a, add_b}), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'h0);
    end

    // Load and start together: load wins
    load = 1'b1; load_sel = 3'b010; load_val = 16'h1234; start = 1'b1;
    tick();
    load = 1'b0; load_sel = 3'b000; start = 1'b0;
    check("ls_pos_y", 32'(pos_y), 32'h1234);
    check("ls_pos_x", 32'(pos_x), 32'h0);
    check("ls_busy", 32'(busy), 32'h0);
    tick();
    check("ls_busy2", 32'(busy), 32'h0);

    // load with empty select has no effect
    load = 1'b1; load_sel = 3'b000; load_val = 16'hABCD;
    tick();
    load = 1'b0;
    check("nosel_pos_y", 32'(pos_y), 32'h1234);
    check("nosel_pos_x", 32'(pos_x), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
